// File: rtl/text_write_ctrl_pkg.sv
// Shared constants, state/command enums and byte classification for the text write path.
package text_buf_pkg;

  localparam int ROWS_DEF = 32;
  localparam int COLS_DEF = 4;

  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_BLANK = 8'h00;
  localparam logic [7:0] PRINT_LO   = 8'h20;
  localparam logic [7:0] PRINT_HI   = 8'h7E;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CUR_HOLD    = 3'd0,
    CUR_ADVANCE = 3'd1,
    CUR_RETREAT = 3'd2,
    CUR_NEWLINE = 3'd3,
    CUR_CR      = 3'd4,
    CUR_HOME    = 3'd5
  } cur_cmd_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/text_write_ctrl_if.sv
// Byte stream in plus RAM write bus out; the controller sits on the slave modport.
interface text_write_ctrl_if #(
  parameter int ROW_W = 5,
  parameter int COL_W = 2
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             we;
  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;
  logic [7:0]       din;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, we, w_row, w_col, din
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, we, w_row, w_col, din
  );
endinterface

// File: rtl/text_write_ctrl_cursor.sv
// Row/column cursor with wrap rules; also serves as the address counter of the clear sweep.
module text_cursor
  import text_buf_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int COLS  = COLS_DEF,
  parameter int ROW_W = 5,
  parameter int COL_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  cur_cmd_t         cmd,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] adv_row,
  output logic [COL_W-1:0] adv_col,
  output logic [ROW_W-1:0] ret_row,
  output logic [COL_W-1:0] ret_col
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

  logic [ROW_W-1:0] row_r, row_inc_s, row_nxt_s;
  logic [COL_W-1:0] col_r, col_nxt_s;

  // Neighbouring positions: one cell forward and one cell back, wrapping at the screen edges.
  always_comb begin
    row_inc_s = (row_r == ROW_LAST) ? ROW_ZERO : row_r + ROW_ONE;
    if (col_r == COL_LAST) begin
      adv_row = row_inc_s;
      adv_col = COL_ZERO;
    end else begin
      adv_row = row_r;
      adv_col = col_r + COL_ONE;
    end
    if (col_r == COL_ZERO) begin
      ret_row = (row_r == ROW_ZERO) ? ROW_LAST : row_r - ROW_ONE;
      ret_col = COL_LAST;
    end else begin
      ret_row = row_r;
      ret_col = col_r - COL_ONE;
    end
  end

  // Command decode into the next cursor position.
  always_comb begin
    row_nxt_s = row_r;
    col_nxt_s = col_r;
    case (cmd)
      CUR_HOLD:    begin row_nxt_s = row_r;     col_nxt_s = col_r;    end
      CUR_ADVANCE: begin row_nxt_s = adv_row;   col_nxt_s = adv_col;  end
      CUR_RETREAT: begin row_nxt_s = ret_row;   col_nxt_s = ret_col;  end
      CUR_NEWLINE: begin row_nxt_s = row_inc_s; col_nxt_s = COL_ZERO; end
      CUR_CR:      begin row_nxt_s = row_r;     col_nxt_s = COL_ZERO; end
      CUR_HOME:    begin row_nxt_s = ROW_ZERO;  col_nxt_s = COL_ZERO; end
      default:     begin row_nxt_s = row_r;     col_nxt_s = col_r;    end
    endcase
  end

  // Cursor register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_r <= ROW_ZERO;
      col_r <= COL_ZERO;
    end else begin
      row_r <= row_nxt_s;
      col_r <= col_nxt_s;
    end
  end

  assign row = row_r;
  assign col = col_r;

endmodule

// File: rtl/text_write_ctrl.sv
// Turns a received byte stream into character-RAM writes, handling CR/LF/BS and a paced FF clear.
// Backspace support is enabled by defining TEXT_WRITE_BACKSPACE_EN; otherwise 0x08 is discarded.
module text_write_ctrl
  import text_buf_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int COLS  = COLS_DEF,
  parameter int ROW_W = 5,
  parameter int COL_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  text_write_ctrl_if.slave  bus,
  output logic              busy,
  output logic [ROW_W-1:0]  cur_row,
  output logic [COL_W-1:0]  cur_col
);

`ifdef TEXT_WRITE_BACKSPACE_EN
  localparam logic BS_EN = 1'b1;
`else
  localparam logic BS_EN = 1'b0;
`endif

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};

  state_t           state_r, next_state_s;
  cur_cmd_t         cmd_s;
  logic [7:0]       byte_r;
  logic             we_r, we_s;
  logic [ROW_W-1:0] w_row_r, w_row_s, adv_row_s, ret_row_s;
  logic [COL_W-1:0] w_col_r, w_col_s, adv_col_s, ret_col_s;
  logic [7:0]       din_r, din_s;
  logic             at_origin_s, at_last_s;

  text_cursor #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)) u_cursor (
    .clk     (clk),
    .reset   (reset),
    .cmd     (cmd_s),
    .row     (cur_row),
    .col     (cur_col),
    .adv_row (adv_row_s),
    .adv_col (adv_col_s),
    .ret_row (ret_row_s),
    .ret_col (ret_col_s)
  );

  assign at_origin_s = (cur_row == ROW_ZERO) && (cur_col == COL_ZERO);
  assign at_last_s   = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  // Writes are decided on the accepting edge so they appear in EXEC, while the
  // cursor moves at the end of EXEC; the sweep loads the next cell address each cycle.
  always_comb begin
    next_state_s = state_r;
    cmd_s        = CUR_HOLD;
    we_s         = 1'b0;
    w_row_s      = w_row_r;
    w_col_s      = w_col_r;
    din_s        = din_r;
    case (state_r)
      IDLE: begin
        if (bus.rx_valid) begin
          next_state_s = EXEC;
          if (is_printable(bus.rx_data)) begin
            we_s    = 1'b1;
            w_row_s = cur_row;
            w_col_s = cur_col;
            din_s   = bus.rx_data;
          end else if (BS_EN && (bus.rx_data == CHAR_BS) && !at_origin_s) begin
            we_s    = 1'b1;
            w_row_s = ret_row_s;
            w_col_s = ret_col_s;
            din_s   = CHAR_BLANK;
          end else begin
            we_s = 1'b0;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC: begin
        next_state_s = IDLE;
        if (is_printable(byte_r)) begin
          cmd_s = CUR_ADVANCE;
        end else if (byte_r == CHAR_CR) begin
          cmd_s = CUR_CR;
        end else if (byte_r == CHAR_LF) begin
          cmd_s = CUR_NEWLINE;
        end else if (BS_EN && (byte_r == CHAR_BS) && !at_origin_s) begin
          cmd_s = CUR_RETREAT;
        end else if (byte_r == CHAR_FF) begin
          cmd_s        = CUR_HOME;
          next_state_s = CLEAR;
          we_s         = 1'b1;
          w_row_s      = ROW_ZERO;
          w_col_s      = COL_ZERO;
          din_s        = CHAR_BLANK;
        end else begin
          cmd_s = CUR_HOLD;
        end
      end
      CLEAR: begin
        // Advancing past the last cell wraps the cursor back to home.
        cmd_s = CUR_ADVANCE;
        if (at_last_s) begin
          next_state_s = IDLE;
          we_s         = 1'b0;
        end else begin
          we_s    = 1'b1;
          w_row_s = adv_row_s;
          w_col_s = adv_col_s;
          din_s   = CHAR_BLANK;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, captured byte and registered RAM write outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      byte_r  <= 8'h00;
      we_r    <= 1'b0;
      w_row_r <= ROW_ZERO;
      w_col_r <= COL_ZERO;
      din_r   <= 8'h00;
    end else begin
      state_r <= next_state_s;
      if ((state_r == IDLE) && bus.rx_valid) begin
        byte_r <= bus.rx_data;
      end
      we_r    <= we_s;
      w_row_r <= w_row_s;
      w_col_r <= w_col_s;
      din_r   <= din_s;
    end
  end

  assign bus.rx_ready = (state_r == IDLE);
  assign bus.we       = we_r;
  assign bus.w_row    = w_row_r;
  assign bus.w_col    = w_col_r;
  assign bus.din      = din_r;
  assign busy         = (state_r == CLEAR);

endmodule

// File: tb/tb_text_write_ctrl.sv
// Directed self-checking bench for text_write_ctrl (default geometry 32x4).
module tb_text_write_ctrl;
  import text_buf_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [4:0] cur_row;
  logic [1:0] cur_col;

  int errors = 0;
  int checks = 0;

  logic       o_we, o_rdy;
  logic [4:0] o_row;
  logic [1:0] o_col;
  logic [7:0] o_din;

  text_write_ctrl_if #(.ROW_W(5), .COL_W(2)) bus ();

  text_write_ctrl #(.ROWS(32), .COLS(4), .ROW_W(5), .COL_W(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .cur_row (cur_row),
    .cur_col (cur_col)
  );

  always #5 clk = ~clk;

  // Offers a byte, waits for acceptance, captures the EXEC-cycle outputs and returns one cycle later.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout byte=%h rx_ready=%b required 1", b, bus.rx_ready);
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    o_we  = bus.we;
    o_row = bus.w_row;
    o_col = bus.w_col;
    o_din = bus.din;
    o_rdy = bus.rx_ready;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if ({bus.we, bus.w_row, bus.w_col, bus.din} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_wbus got we=%b row=%0d col=%0d din=%h required all zero",
               bus.we, bus.w_row, bus.w_col, bus.din);
    end
    checks++;
    if ({busy, cur_row, cur_col, bus.rx_ready} !== {1'b0, 5'd0, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got busy=%b cur=(%0d,%0d) rdy=%b required 0 (0,0) 1",
               busy, cur_row, cur_col, bus.rx_ready);
    end
  endtask

  task automatic test_printable();
    int bad;
    logic [7:0] ch;
    send_byte(8'h41);
    checks++;
    if ({o_we, o_row, o_col, o_din, o_rdy} !== {1'b1, 5'd0, 2'd0, 8'h41, 1'b0}) begin
      errors++;
      $display("FAIL first_write got we=%b (%0d,%0d) din=%h rdy=%b required 1 (0,0) 41 0",
               o_we, o_row, o_col, o_din, o_rdy);
    end
    checks++;
    if ({cur_row, cur_col, bus.we} !== {5'd0, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL first_cursor got (%0d,%0d) we=%b required (0,1) 0", cur_row, cur_col, bus.we);
    end
    for (int i = 1; i < 4; i++) begin
      ch = 8'h41 + 8'(i);
      send_byte(ch);
      checks++;
      if ({o_we, o_row, o_col, o_din} !== {1'b1, 5'd0, 2'(i), ch}) begin
        errors++;
        $display("FAIL row0_write%0d got we=%b (%0d,%0d) din=%h required 1 (0,%0d) %h",
                 i, o_we, o_row, o_col, o_din, i, ch);
      end
    end
    checks++;
    if ({cur_row, cur_col} !== {5'd1, 2'd0}) begin
      errors++;
      $display("FAIL row0_cursor got (%0d,%0d) required (1,0)", cur_row, cur_col);
    end
    bad = 0;
    for (int i = 4; i < 128; i++) begin
      ch = 8'h21 + 8'(i % 90);
      send_byte(ch);
      if ({o_we, o_row, o_col, o_din} !== {1'b1, 5'(i / 4), 2'(i % 4), ch}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fill_writes got %0d bad writes required 0", bad);
    end
    checks++;
    if ({cur_row, cur_col} !== {5'd0, 2'd0}) begin
      errors++;
      $display("FAIL fill_wrap got (%0d,%0d) required (0,0)", cur_row, cur_col);
    end
  endtask

  task automatic test_cr_lf();
    for (int i = 0; i < 11; i++) send_byte(8'h61);
    checks++;
    if ({cur_row, cur_col} !== {5'd2, 2'd3}) begin
      errors++;
      $display("FAIL setup_23 got (%0d,%0d) required (2,3)", cur_row, cur_col);
    end
    send_byte(CHAR_CR);
    checks++;
    if ({o_we, cur_row, cur_col} !== {1'b0, 5'd2, 2'd0}) begin
      errors++;
      $display("FAIL cr got we=%b (%0d,%0d) required 0 (2,0)", o_we, cur_row, cur_col);
    end
    send_byte(CHAR_LF);
    checks++;
    if ({o_we, cur_row, cur_col} !== {1'b0, 5'd3, 2'd0}) begin
      errors++;
      $display("FAIL lf got we=%b (%0d,%0d) required 0 (3,0)", o_we, cur_row, cur_col);
    end
    for (int i = 0; i < 28; i++) send_byte(CHAR_LF);
    checks++;
    if ({cur_row, cur_col} !== {5'd31, 2'd0}) begin
      errors++;
      $display("FAIL lf_to_31 got (%0d,%0d) required (31,0)", cur_row, cur_col);
    end
    send_byte(CHAR_LF);
    checks++;
    if ({o_we, cur_row, cur_col} !== {1'b0, 5'd0, 2'd0}) begin
      errors++;
      $display("FAIL lf_wrap got we=%b (%0d,%0d) required 0 (0,0)", o_we, cur_row, cur_col);
    end
  endtask

  task automatic test_backspace();
    for (int i = 0; i < 4; i++) send_byte(8'h30);
    send_byte(CHAR_BS);
`ifdef TEXT_WRITE_BACKSPACE_EN
    checks++;
    if ({o_we, o_row, o_col, o_din, cur_row, cur_col} !== {1'b1, 5'd0, 2'd3, 8'h00, 5'd0, 2'd3}) begin
      errors++;
      $display("FAIL bs_retreat got we=%b (%0d,%0d) din=%h cur=(%0d,%0d) required 1 (0,3) 00 (0,3)",
               o_we, o_row, o_col, o_din, cur_row, cur_col);
    end
    send_byte(CHAR_CR);
`else
    checks++;
    if ({o_we, cur_row, cur_col} !== {1'b0, 5'd1, 2'd0}) begin
      errors++;
      $display("FAIL bs_disabled got we=%b cur=(%0d,%0d) required 0 (1,0)", o_we, cur_row, cur_col);
    end
    for (int i = 0; i < 31; i++) send_byte(CHAR_LF);
`endif
    send_byte(CHAR_BS);
    checks++;
    if ({o_we, cur_row, cur_col} !== {1'b0, 5'd0, 2'd0}) begin
      errors++;
      $display("FAIL bs_origin got we=%b cur=(%0d,%0d) required 0 (0,0)", o_we, cur_row, cur_col);
    end
  endtask

  task automatic test_discard();
    logic [7:0] junk [4];
    int bad;
    junk[0] = 8'h1B; junk[1] = 8'hFF; junk[2] = 8'h00; junk[3] = 8'h7F;
    send_byte(8'h78);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      send_byte(junk[i]);
      if ({o_we, o_rdy, cur_row, cur_col} !== {1'b0, 1'b0, 5'd0, 2'd1}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL discard got %0d bad bytes required 0 (cur=(%0d,%0d))", bad, cur_row, cur_col);
    end
  endtask

  task automatic test_clear_sweep();
    int bad;
    send_byte(CHAR_FF);
    bus.rx_data  = 8'h5A;
    bus.rx_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 128; k++) begin
      if ({busy, bus.rx_ready, bus.we, bus.w_row, bus.w_col, bus.din} !==
          {1'b1, 1'b0, 1'b1, 5'(k / 4), 2'(k % 4), 8'h00}) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep_cycles got %0d bad cycles required 0", bad);
    end
    checks++;
    if ({bus.we, busy, bus.rx_ready, cur_row, cur_col} !== {1'b0, 1'b0, 1'b1, 5'd0, 2'd0}) begin
      errors++;
      $display("FAIL sweep_end got we=%b busy=%b rdy=%b cur=(%0d,%0d) required 0 0 1 (0,0)",
               bus.we, busy, bus.rx_ready, cur_row, cur_col);
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    checks++;
    if ({bus.we, bus.w_row, bus.w_col, bus.din} !== {1'b1, 5'd0, 2'd0, 8'h5A}) begin
      errors++;
      $display("FAIL held_byte got we=%b (%0d,%0d) din=%h required 1 (0,0) 5a",
               bus.we, bus.w_row, bus.w_col, bus.din);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_clear();
    int bad;
    send_byte(CHAR_FF);
    repeat (40) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.we, busy, cur_row, cur_col, bus.w_row, bus.w_col} !== {1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0}) begin
      errors++;
      $display("FAIL async_reset got we=%b busy=%b cur=(%0d,%0d) w=(%0d,%0d) required 0 0 (0,0) (0,0)",
               bus.we, busy, cur_row, cur_col, bus.w_row, bus.w_col);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 0;
    repeat (5) begin
      if (bus.we !== 1'b0 || busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_quiet got %0d cycles with writes required 0", bad);
    end
    send_byte(8'h71);
    send_byte(8'h1B);
    checks++;
    if ({o_we, cur_row, cur_col} !== {1'b0, 5'd0, 2'd1}) begin
      errors++;
      $display("FAIL discard_1b got we=%b cur=(%0d,%0d) required 0 (0,1)", o_we, cur_row, cur_col);
    end
    send_byte(8'hFF);
    checks++;
    if ({o_we, cur_row, cur_col} !== {1'b0, 5'd0, 2'd1}) begin
      errors++;
      $display("FAIL discard_ff got we=%b cur=(%0d,%0d) required 0 (0,1)", o_we, cur_row, cur_col);
    end
  endtask

  initial begin
    test_reset();
    test_printable();
    test_cr_lf();
    test_backspace();
    test_discard();
    test_clear_sweep();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
